audio_decimator: RTL and testbench

Decimating N-stage CIC filter that converts the demodulated baseband stream at 960 kHz into 32 kHz audio samples. Sits directly downstream of the clock and reset unit. Its integrators advance on `en960k`, its combs advance on `en32k`, and it runs entirely in the 240 MHz domain. Output samples feed the audio output stage, one `dout_valid` pulse per 32 kHz period.

---
 rtl/audio_decimator.sv | 108 ++++++++++
 tb/tb_audio_decimator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_decimator.sv
// audio_decimator: N-stage CIC decimator (M=1); integrators step on en960k, combs on en32k&en960k.
// Optional build macro AUDIO_DECIMATOR_ROUND_EN selects round-half-up with saturation instead of truncation.
module audio_decimator #(
  parameter int N     = 3,
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int W_ACC = W_IN + 5*N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en960k,
  input  logic                    en32k,
  input  logic signed [W_IN-1:0]  din,
  output logic signed [W_OUT-1:0] dout,
  output logic                    dout_valid
);
  localparam int S = W_ACC - W_OUT;

  logic             w_dec_en;
  logic [W_ACC-1:0] w_din_ext;
  logic [W_ACC-1:0] w_last_integ;
  logic [W_ACC-1:0] r_comb_out;
  logic             r_valid;

  // A stray en32k without en960k must not touch any state.
  assign w_dec_en  = en32k & en960k;
  assign w_din_ext = {{(W_ACC-W_IN){din[W_IN-1]}}, din};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic [W_ACC-1:0] r_acc;
      logic [W_ACC-1:0] r_dly;
      logic [W_ACC-1:0] w_acc_in;
      logic [W_ACC-1:0] w_x;
      logic [W_ACC-1:0] w_diff;

      if (gi == 0) begin : g_head
        assign w_acc_in = w_din_ext;
        assign w_x      = w_last_integ;
      end else begin : g_tail
        // Integrators use the previous stage's old value (registered cascade).
        assign w_acc_in = g_stage[gi-1].r_acc;
        assign w_x      = g_stage[gi-1].w_diff;
      end

      assign w_diff = w_x - r_dly;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_acc <= '0;
          r_dly <= '0;
        end else begin
          if (en960k) begin
            r_acc <= r_acc + w_acc_in;
          end
          if (w_dec_en) begin
            r_dly <= w_x;
          end
        end
      end
    end
  endgenerate

  assign w_last_integ = g_stage[N-1].r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_comb_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_dec_en;
      if (w_dec_en) begin
        r_comb_out <= g_stage[N-1].w_diff;
      end
    end
  end

  assign dout_valid = r_valid;

`ifdef AUDIO_DECIMATOR_ROUND_EN
  localparam logic [W_ACC:0]   L_HALF = (W_ACC+1)'(1) << (S-1);
  localparam logic [W_OUT-1:0] L_MAX  = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] L_MIN  = {1'b1, {(W_OUT-1){1'b0}}};

  logic [W_ACC:0] w_rounded;
  logic [W_OUT:0] w_shifted;
  logic           w_unused_lsbs;

  // One guard bit keeps the +half from wrapping a large positive value negative.
  assign w_rounded     = {r_comb_out[W_ACC-1], r_comb_out} + L_HALF;
  assign w_shifted     = w_rounded[W_ACC:S];
  assign w_unused_lsbs = &{1'b0, w_rounded[S-1:0]};

  always_comb begin
    dout = w_shifted[W_OUT-1:0];
    if (w_shifted[W_OUT] != w_shifted[W_OUT-1]) begin
      dout = w_shifted[W_OUT] ? L_MIN : L_MAX;
    end
  end
`else
  logic w_unused_lsbs;

  assign dout          = r_comb_out[W_ACC-1:S];
  assign w_unused_lsbs = &{1'b0, r_comb_out[S-1:0]};
`endif

endmodule

// File: tb/tb_audio_decimator.sv
// tb_audio_decimator: directed table of DC/full-scale step responses plus wrap, stray-strobe and random sequences.
module tb_audio_decimator;
  localparam int P = 4;    // clk cycles per en960k (compressed from 250)
  localparam int R = 30;   // en960k pulses per en32k
  localparam longint MASK = (64'sd1 <<< 31) - 64'sd1;

  logic               clk = 1'b0;
  logic               reset;
  logic               en960k;
  logic               en32k;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic               dout_valid;

  always #5 clk = ~clk;

  audio_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .en960k     (en960k),
    .en32k      (en32k),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Valid-pulse monitor: total high cycles and spacing between pulses.
  int cyc = 0;
  int n_valid_seen = 0;
  int last_valid_cyc = -1;
  int valid_gap = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      n_valid_seen++;
      if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
  end

  // Reference: N=3 integrators, output = third difference of decimated samples, modulo 2^31.
  longint m_i[3];
  longint m_h[3];
  longint m_exp;
  int     n_valid_exp = 0;

  function automatic longint to_dout(input longint y);
    longint s;
    longint r;
    s = (y >= (64'sd1 <<< 30)) ? y - (64'sd1 <<< 31) : y;
`ifdef AUDIO_DECIMATOR_ROUND_EN
    r = (s + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = s >>> 15;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_i[k] = 0;
      m_h[k] = 0;
    end
    m_exp = 0;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1; en960k = 1'b1; en32k = 1'b1; din = 16'sd1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (chk) begin
        check($sformatf("reset%0d_dout", i), dout, 0);
        check($sformatf("reset%0d_valid", i), dout_valid, 0);
      end
    end
    reset = 1'b0; en960k = 1'b0; en32k = 1'b0;
    tick();
    if (chk) begin
      check("post_reset_dout", dout, 0);
      check("post_reset_valid", dout_valid, 0);
    end
    model_clear();
  endtask

  task automatic run_sample(input logic signed [15:0] d, input bit e32,
                            output logic v_out, output longint d_out);
    longint v;
    longint y;
    en960k = 1'b1; en32k = e32; din = d;
    if (e32) begin
      v = m_i[2];
      y = (v - 3*m_h[0] + 3*m_h[1] - m_h[2]) & MASK;
      m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = v;
      m_exp = to_dout(y);
      n_valid_exp++;
    end
    m_i[2] = (m_i[2] + m_i[1]) & MASK;
    m_i[1] = (m_i[1] + m_i[0]) & MASK;
    m_i[0] = (m_i[0] + longint'(d)) & MASK;
    tick();
    v_out = dout_valid;
    d_out = dout;
    en960k = 1'b0; en32k = 1'b0;
    repeat (P-1) tick();
  endtask

  // One decimation period; the last en960k carries en32k.
  task automatic run_block(input bit rnd, input logic signed [15:0] d, input int n,
                           output logic v_out, output longint d_out, output longint hold);
    logic signed [15:0] s;
    logic   v;
    longint o;
    v_out = 1'b0; d_out = 0;
    for (int i = 0; i < n; i++) begin
      s = rnd ? 16'($urandom) : d;
      run_sample(s, i == n-1, v, o);
      if (i == n-1) begin
        v_out = v;
        d_out = o;
      end
    end
    hold = dout;
  endtask

  typedef struct {
    logic signed [15:0] din;
    int                 blk;
    int                 exp_trunc;
    int                 exp_round;
  } vec_t;

  vec_t   vecs[15];
  logic   got_v;
  longint got_d;
  longint hold_d;
  longint exp_d;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{16'sd1000,  0,    111,    112},
      '{16'sd1000,  1,    657,    658},
      '{16'sd1000,  2,    823,    824},
      '{16'sd1000,  3,    823,    824},
      '{16'sd1000,  4,    823,    824},
      '{16'sd32767, 0,   3653,   3654},
      '{16'sd32767, 1,  21546,  21546},
      '{16'sd32767, 2,  26998,  26998},
      '{16'sd32767, 3,  26999,  26999},
      '{16'sd32767, 4,  26999,  26999},
      '{16'sh8000,  0,  -3654,  -3654},
      '{16'sh8000,  1, -21547, -21547},
      '{16'sh8000,  2, -26999, -26999},
      '{16'sh8000,  3, -27000, -27000},
      '{16'sh8000,  4, -27000, -27000}
    };
    reset = 1'b0; en960k = 1'b0; en32k = 1'b0; din = '0;
    model_clear();

    // Step responses from a freshly reset filter (reset lands mid-operation after the first segment).
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].blk == 0) do_reset(i == 0);
      run_block(1'b0, vecs[i].din, R, got_v, got_d, hold_d);
`ifdef AUDIO_DECIMATOR_ROUND_EN
      exp_d = vecs[i].exp_round;
`else
      exp_d = vecs[i].exp_trunc;
`endif
      check($sformatf("vec%0d_dout", i), got_d, exp_d);
      check($sformatf("vec%0d_valid", i), got_v, 1);
      if (vecs[i].blk > 0) check($sformatf("vec%0d_gap", i), valid_gap, R*P);
      if (vecs[i].blk == 4) check($sformatf("vec%0d_hold", i), hold_d, exp_d);
    end

    // Integrator wrap: long positive full-scale run, then zeros settle to exactly 0.
    do_reset(1'b0);
    for (int b = 0; b < 40; b++) run_block(1'b0, 16'sd32767, R, got_v, got_d, hold_d);
    check("wrap_full", got_d, 26999);
    for (int b = 0; b < 5; b++) begin
      run_block(1'b0, 16'sd0, R, got_v, got_d, hold_d);
      check($sformatf("wrap_zero%0d_model", b), got_d, m_exp);
      if (b >= 3) check($sformatf("wrap_zero%0d", b), got_d, 0);
    end

    // Stray en32k without en960k: no pulse, no state change.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) run_sample(16'($urandom), 1'b0, got_v, got_d);
    en32k = 1'b1; en960k = 1'b0; din = 16'sd5000;
    tick();
    check("stray_valid", dout_valid, 0);
    check("stray_dout", dout, 0);
    en32k = 1'b0;
    tick();
    check("stray_valid_late", dout_valid, 0);
    run_block(1'b1, 16'sd0, R-10, got_v, got_d, hold_d);
    check("stray_blk0", got_d, m_exp);
    for (int b = 1; b < 3; b++) begin
      run_block(1'b1, 16'sd0, R, got_v, got_d, hold_d);
      check($sformatf("stray_blk%0d", b), got_d, m_exp);
    end

    // Random samples against the reference.
    do_reset(1'b0);
    for (int b = 0; b < 20; b++) begin
      run_block(1'b1, 16'sd0, R, got_v, got_d, hold_d);
      check($sformatf("rand%0d_dout", b), got_d, m_exp);
    end

    repeat (3) tick();
    check("valid_count", n_valid_seen, n_valid_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
